// File: rtl/sr04_pkg.sv
// sr04_pkg: shared constants and BCD converter state encoding for sr04_dist_filter
// Contents: DIST_W (distance width), default accepted range MIN_CM_DEF/MAX_CM_DEF,
// bcd_state_e (IDLE/SHIFT/DONE) used by dist_bin2bcd.
package sr04_pkg;
    localparam int DIST_W     = 9;
    localparam int MIN_CM_DEF = 2;
    localparam int MAX_CM_DEF = 400;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} bcd_state_e;
endpackage

// File: rtl/sr04_dist_filter_if.sv
// sr04_dist_filter_if: sample input / filtered output bundle of sr04_dist_filter
// master: drives i_dist, i_dist_valid, i_clear; observes o_dist, o_dist_valid, o_reject, o_full.
// slave : the filter side of the same signals.
// With SR04_FILTER_BCD_EN the BCD digits o_bcd_hund/tens/ones and o_bcd_valid are added.
interface sr04_dist_filter_if;
    import sr04_pkg::*;
    logic [DIST_W-1:0] i_dist;
    logic              i_dist_valid;
    logic              i_clear;
    logic [DIST_W-1:0] o_dist;
    logic              o_dist_valid;
    logic              o_reject;
    logic              o_full;
`ifdef SR04_FILTER_BCD_EN
    logic [3:0]        o_bcd_hund, o_bcd_tens, o_bcd_ones;
    logic              o_bcd_valid;
    modport master (output i_dist, i_dist_valid, i_clear,
                    input  o_dist, o_dist_valid, o_reject, o_full,
                    input  o_bcd_hund, o_bcd_tens, o_bcd_ones, o_bcd_valid);
    modport slave  (input  i_dist, i_dist_valid, i_clear,
                    output o_dist, o_dist_valid, o_reject, o_full,
                    output o_bcd_hund, o_bcd_tens, o_bcd_ones, o_bcd_valid);
`else
    modport master (output i_dist, i_dist_valid, i_clear,
                    input  o_dist, o_dist_valid, o_reject, o_full);
    modport slave  (input  i_dist, i_dist_valid, i_clear,
                    output o_dist, o_dist_valid, o_reject, o_full);
`endif
endinterface

// File: rtl/dist_bin2bcd.sv
// dist_bin2bcd: sequential double-dabble converter, 9-bit binary to three BCD digits
// Ports: clk, rst (async active-low), i_start (load i_bin, restarts any conversion),
// i_bin, o_bcd_hund/o_bcd_tens/o_bcd_ones (held until the next result), o_done (1-cycle strobe).
// Timing: load at the i_start cycle T, shifts on T+1..T+9, digits and o_done at T+10.
module dist_bin2bcd
    import sr04_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DIST_W-1:0] i_bin,
    output logic [3:0]        o_bcd_hund,
    output logic [3:0]        o_bcd_tens,
    output logic [3:0]        o_bcd_ones,
    output logic              o_done
);
    localparam int SH_W = 12 + DIST_W;

    bcd_state_e      state_q, state_d;
    logic [SH_W-1:0] sh_q, sh_d, sh_adj;
    logic [3:0]      cnt_q, cnt_d;
    logic [11:0]     dig_q, dig_d;
    logic            last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    // a fresh start always wins, so only the newest value ever completes
    always_comb begin
        last    = state_q == SHIFT && cnt_q == 4'd8;
        state_d = i_start ? SHIFT : (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end

    always_comb begin
        sh_adj = sh_q;
        for (int k = 0; k < 3; k++)
            if (sh_q[DIST_W+4*k +: 4] >= 4'd5)
                sh_adj[DIST_W+4*k +: 4] = sh_q[DIST_W+4*k +: 4] + 4'd3;
        sh_d  = i_start ? {12'd0, i_bin} : (state_q == SHIFT) ? sh_adj << 1 : sh_q;
        cnt_d = i_start ? '0 : (state_q == SHIFT) ? cnt_q + 4'd1 : cnt_q;
        dig_d = (!i_start && last) ? sh_d[SH_W-1 -: 12] : dig_q;
        o_done = state_q == DONE;
    end

    assign {o_bcd_hund, o_bcd_tens, o_bcd_ones} = dig_q;
endmodule

// File: rtl/sr04_dist_filter.sv
// sr04_dist_filter: range check + moving average over the last 2^DEPTH_LOG2 accepted samples
// Ports: clk, rst (async active-low), bus (sr04_dist_filter_if.slave): i_dist/i_dist_valid
// sample in, i_clear flush; o_dist/o_dist_valid filtered result, o_reject range strobe,
// o_full window-filled flag. Define SR04_FILTER_BCD_EN to add the BCD digit outputs.
module sr04_dist_filter
    import sr04_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int MIN_CM     = MIN_CM_DEF,
    parameter int MAX_CM     = MAX_CM_DEF
) (
    input  logic                clk,
    input  logic                rst,
    sr04_dist_filter_if.slave   bus
);
    localparam int N     = 1 << DEPTH_LOG2;
    localparam int SUM_W = DIST_W + DEPTH_LOG2;
    localparam int FW    = DEPTH_LOG2 + 1;
    localparam logic [DIST_W-1:0] MIN_V = DIST_W'(MIN_CM);
    localparam logic [DIST_W-1:0] MAX_V = DIST_W'(MAX_CM);

    logic [DIST_W-1:0]     mem_q [N];
    logic [DIST_W-1:0]     mem_d [N];
    logic [SUM_W-1:0]      sum_q, sum_d, sum_nxt;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [DIST_W-1:0]     dist_q, dist_d;
    logic                  dist_valid_q, dist_valid_d;
    logic                  reject_q, reject_d;
    logic                  full_q, full_d;
    logic                  sample, accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q        <= '{default: '0};
            sum_q        <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            dist_q       <= '0;
            dist_valid_q <= 1'b0;
            reject_q     <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            sum_q        <= sum_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            dist_q       <= dist_d;
            dist_valid_q <= dist_valid_d;
            reject_q     <= reject_d;
            full_q       <= full_d;
        end
    end

    always_comb begin
        // clear drops a colliding sample entirely, including its reject strobe
        sample  = bus.i_dist_valid && !bus.i_clear;
        accept  = sample && bus.i_dist >= MIN_V && bus.i_dist <= MAX_V;
        // unfilled slots hold zero, so subtracting the evicted slot is always safe
        sum_nxt = sum_q - SUM_W'(mem_q[wr_ptr_q]) + SUM_W'(bus.i_dist);
        mem_d   = mem_q;
        if (bus.i_clear)
            mem_d = '{default: '0};
        else if (accept)
            mem_d[wr_ptr_q] = bus.i_dist;
        sum_d        = bus.i_clear ? '0 : accept ? sum_nxt : sum_q;
        wr_ptr_d     = bus.i_clear ? '0 : accept ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        fill_d       = bus.i_clear ? '0 : (accept && fill_q != FW'(N)) ? fill_q + FW'(1) : fill_q;
        // pass-through until this sample completes the window, then the truncated mean
        dist_d       = bus.i_clear ? '0 :
                       accept ? ((fill_q < FW'(N - 1)) ? bus.i_dist : sum_nxt[SUM_W-1:DEPTH_LOG2]) :
                       dist_q;
        full_d       = fill_d == FW'(N);
        dist_valid_d = accept;
        reject_d     = sample && !accept;
    end

    assign bus.o_dist       = dist_q;
    assign bus.o_dist_valid = dist_valid_q;
    assign bus.o_reject     = reject_q;
    assign bus.o_full       = full_q;

`ifdef SR04_FILTER_BCD_EN
    dist_bin2bcd u_bcd (
        .clk        (clk),
        .rst        (rst),
        .i_start    (dist_valid_q),
        .i_bin      (dist_q),
        .o_bcd_hund (bus.o_bcd_hund),
        .o_bcd_tens (bus.o_bcd_tens),
        .o_bcd_ones (bus.o_bcd_ones),
        .o_done     (bus.o_bcd_valid)
    );
`endif
endmodule

// File: tb/tb_sr04_dist_filter.sv
// tb_sr04_dist_filter: self-checking bench for sr04_dist_filter (DEPTH_LOG2=2, 2..400 cm)
// Covers the BCD path as well when built with SR04_FILTER_BCD_EN.
module tb_sr04_dist_filter;
    localparam int DL = 2;
    localparam int N  = 1 << DL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sr04_dist_filter_if bus ();
    sr04_dist_filter #(.DEPTH_LOG2(DL), .MIN_CM(2), .MAX_CM(400)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit v; bit c; int d;
        bit e_v; bit e_r; int e_dist; bit e_full;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int q[$];
    int m_dist = 0;
    bit m_full = 1'b0;
    bit m_v = 1'b0;
    bit m_r = 1'b0;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference: keep the accepted samples themselves, average whole window
    task automatic step(input bit v, input int d, input bit c);
        @(negedge clk);
        bus.i_dist_valid = v;
        bus.i_dist       = 9'(d);
        bus.i_clear      = c;
        m_v = 1'b0;
        m_r = 1'b0;
        if (c) begin
            q.delete();
            m_dist = 0;
            m_full = 1'b0;
        end else if (v && d >= 2 && d <= 400) begin
            q.push_back(d);
            if (q.size() > N) void'(q.pop_front());
            m_v = 1'b1;
            if (q.size() < N) m_dist = d;
            else begin
                int s;
                s = 0;
                foreach (q[i]) s += q[i];
                m_dist = s / N;
            end
            m_full = q.size() == N;
        end else if (v) m_r = 1'b1;
        @(posedge clk);
        #1;
        check("o_dist", bus.o_dist, m_dist);
        check("o_dist_valid", bus.o_dist_valid, m_v);
        check("o_reject", bus.o_reject, m_r);
        check("o_full", bus.o_full, m_full);
    endtask

    initial begin
        int n;
        bus.i_dist = '0;
        bus.i_dist_valid = 1'b0;
        bus.i_clear = 1'b0;
        #2;
        check("rst_dist", bus.o_dist, 0);
        check("rst_valid", bus.o_dist_valid, 0);
        check("rst_reject", bus.o_reject, 0);
        check("rst_full", bus.o_full, 0);
`ifdef SR04_FILTER_BCD_EN
        check("rst_bcd", {bus.o_bcd_valid, bus.o_bcd_hund, bus.o_bcd_tens, bus.o_bcd_ones}, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        tbl[0] = '{1, 0, 100, 1, 0, 100, 0};
        tbl[1] = '{1, 0, 104, 1, 0, 104, 0};
        tbl[2] = '{1, 0, 108, 1, 0, 108, 0};
        tbl[3] = '{1, 0, 112, 1, 0, 106, 1};
        tbl[4] = '{1, 0, 120, 1, 0, 111, 1};
        tbl[5] = '{1, 0, 450, 0, 1, 111, 1};
        tbl[6] = '{1, 0, 1,   0, 1, 111, 1};
        tbl[7] = '{1, 1, 200, 0, 0, 0,   0};
        tbl[8] = '{1, 0, 50,  1, 0, 50,  0};
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            check($sformatf("tbl%0d_dist", i), bus.o_dist, tbl[i].e_dist);
            check($sformatf("tbl%0d_valid", i), bus.o_dist_valid, tbl[i].e_v);
            check($sformatf("tbl%0d_reject", i), bus.o_reject, tbl[i].e_r);
            check($sformatf("tbl%0d_full", i), bus.o_full, tbl[i].e_full);
        end

        // boundaries of the accepted range
        step(0, 0, 1);
        step(1, 2, 0);
        step(1, 400, 0);
        step(1, 401, 0);
        step(1, 0, 0);

        // back-to-back samples wrap the write pointer
        step(0, 0, 1);
        for (int i = 1; i <= 6; i++) step(1, 10 * i, 0);
        check("b2b_last", bus.o_dist, 45);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 31) == 0);

`ifdef SR04_FILTER_BCD_EN
        step(0, 0, 1);
        step(1, 255, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0);
            check($sformatf("bcd_valid_t%0d", k), bus.o_bcd_valid, k == 10);
        end
        check("bcd_255", {bus.o_bcd_hund, bus.o_bcd_tens, bus.o_bcd_ones}, 12'h255);
        step(1, 37, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0);
        step(1, 123, 0);
        n = 0;
        for (int k = 0; k < 15; k++) begin
            step(0, 0, 0);
            if (bus.o_bcd_valid) begin
                n++;
                check("bcd_123", {bus.o_bcd_hund, bus.o_bcd_tens, bus.o_bcd_ones}, 12'h123);
            end
        end
        check("bcd_abort_pulses", n, 1);
`endif

        // reset in the middle of a conversion with the window full
        step(0, 0, 1);
        for (int k = 0; k < N; k++) step(1, 200 + k, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_dist", bus.o_dist, 0);
        check("mid_rst_valid", bus.o_dist_valid, 0);
        check("mid_rst_reject", bus.o_reject, 0);
        check("mid_rst_full", bus.o_full, 0);
`ifdef SR04_FILTER_BCD_EN
        check("mid_rst_bcd", {bus.o_bcd_valid, bus.o_bcd_hund, bus.o_bcd_tens, bus.o_bcd_ones}, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_dist = 0;
        m_full = 1'b0;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            step(0, 0, 0);
`ifdef SR04_FILTER_BCD_EN
            if (bus.o_bcd_valid) n++;
`endif
        end
        check("post_rst_bcd_pulses", n, 0);
        step(1, 77, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
